// File: rtl/switch_pkg.sv
// Shared types, default parameters and the debounce-length helper
// for the slide-switch debouncer.
package switch_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  localparam int unsigned DEF_N_SW        = 4;
  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_MS = 10;

  function automatic int unsigned calc_db_cycles(input int unsigned clk_hz,
                                                 input int unsigned debounce_ms);
    return clk_hz / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, IDLE/PENDING FSM with a
// saturating-by-construction stability counter, registered edge pulses.
module sw_debounce_bit
  import switch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic stable,
  output logic rose,
  output logic fell
);

  // Guarded so a bad DB_CYCLES reaches the error instead of a zero-width vector.
  localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("sw_debounce_bit: DB_CYCLES must be at least 2");
  end

  logic          sync1_q;
  logic          s_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rose_q, rose_d;
  logic          fell_q, fell_d;
  logic          commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rose_q   <= 1'b0;
      fell_q   <= 1'b0;
    end else begin
      sync1_q  <= sw_in;
      s_q      <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rose_q   <= rose_d;
      fell_q   <= fell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_q != stable_q) begin
          state_d = PENDING;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PENDING: begin
        if (s_q == stable_q || cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Commit happens on the same edge the FSM leaves PENDING with a full count.
  always_comb begin
    commit   = (state_q == PENDING) && (s_q != stable_q) && (cnt_q == CNT_LAST);
    stable_d = commit ? ~stable_q : stable_q;
    rose_d   = commit & ~stable_q;
    fell_d   = commit & stable_q;
  end

  assign stable = stable_q;
  assign rose   = rose_q;
  assign fell   = fell_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW slide switches; one sw_debounce_bit per switch, plus
// a combined change flag derived from the registered edge pulses.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned N_SW        = DEF_N_SW,
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic            CLK_50,
  input  logic            RST_N,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] SW_STABLE,
  output logic [N_SW-1:0] SW_ROSE,
  output logic [N_SW-1:0] SW_FELL,
  output logic            ANY_CHANGE
);

  localparam int unsigned DB_CYCLES = calc_db_cycles(CLK_HZ, DEBOUNCE_MS);

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk    (CLK_50),
      .rst_n  (RST_N),
      .sw_in  (SW[i]),
      .stable (SW_STABLE[i]),
      .rose   (SW_ROSE[i]),
      .fell   (SW_FELL[i])
    );
  end

  // Pure OR of flop outputs, so it lines up exactly with the pulses.
  always_comb begin
    ANY_CHANGE = |(SW_ROSE | SW_FELL);
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DB_CYCLES = 4
// (CLK_HZ=1000, DEBOUNCE_MS=4): stable output changes on edge 6.
module tb_switch_debouncer;

  logic       CLK_50;
  logic       RST_N;
  logic [3:0] SW;
  logic [3:0] SW_STABLE;
  logic [3:0] SW_ROSE;
  logic [3:0] SW_FELL;
  logic       ANY_CHANGE;

  int unsigned tests_run;
  int unsigned tests_failed;

  switch_debouncer #(
    .N_SW       (4),
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .CLK_50     (CLK_50),
    .RST_N      (RST_N),
    .SW         (SW),
    .SW_STABLE  (SW_STABLE),
    .SW_ROSE    (SW_ROSE),
    .SW_FELL    (SW_FELL),
    .ANY_CHANGE (ANY_CHANGE)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  logic [12:0] obs;
  assign obs = {SW_STABLE, SW_ROSE, SW_FELL, ANY_CHANGE};

  task automatic step();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    SW    = 4'b0000;
    repeat (2) step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    SW    = 4'b0000;
    #1;
    tests_run++;
    if (obs !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", obs, 13'd0);
    end
    repeat (2) step();
    RST_N = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      tests_run++;
      if (obs !== 13'd0) begin
        tests_failed++;
        $display("FAIL idle_zero edge %0d: got %b expected %b", e, obs, 13'd0);
      end
    end
  endtask

  task automatic test_single_rise();
    logic [3:0] st, ro;
    do_reset();
    SW = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      step();
      st = (e >= 6) ? 4'b0001 : 4'b0000;
      ro = (e == 6) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (obs !== {st, ro, 4'b0000, (e == 6)}) begin
        tests_failed++;
        $display("FAIL single_rise edge %0d: got %b expected %b", e, obs,
                 {st, ro, 4'b0000, (e == 6)});
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] st, ro;
    do_reset();
    SW = 4'b0010;
    repeat (3) step();
    SW = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      step();
      tests_run++;
      if (obs !== 13'd0) begin
        tests_failed++;
        $display("FAIL glitch_quiet edge %0d: got %b expected %b", e, obs, 13'd0);
      end
    end
    SW = 4'b0010;
    for (int e = 1; e <= 10; e++) begin
      step();
      st = (e >= 6) ? 4'b0010 : 4'b0000;
      ro = (e == 6) ? 4'b0010 : 4'b0000;
      tests_run++;
      if (obs !== {st, ro, 4'b0000, (e == 6)}) begin
        tests_failed++;
        $display("FAIL glitch_then_hold edge %0d: got %b expected %b", e, obs,
                 {st, ro, 4'b0000, (e == 6)});
      end
    end
  endtask

  task automatic test_multi_bit();
    logic [3:0] st, ro, fe;
    do_reset();
    SW = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      step();
      st = (e >= 6) ? 4'b1111 : 4'b0000;
      ro = (e == 6) ? 4'b1111 : 4'b0000;
      tests_run++;
      if (obs !== {st, ro, 4'b0000, (e == 6)}) begin
        tests_failed++;
        $display("FAIL multi_rise edge %0d: got %b expected %b", e, obs,
                 {st, ro, 4'b0000, (e == 6)});
      end
    end
    SW = 4'b1010;
    for (int e = 1; e <= 8; e++) begin
      step();
      st = (e >= 6) ? 4'b1010 : 4'b1111;
      fe = (e == 6) ? 4'b0101 : 4'b0000;
      tests_run++;
      if (obs !== {st, 4'b0000, fe, (e == 6)}) begin
        tests_failed++;
        $display("FAIL multi_fall edge %0d: got %b expected %b", e, obs,
                 {st, 4'b0000, fe, (e == 6)});
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    logic [3:0] st, ro;
    do_reset();
    SW = 4'b0100;
    repeat (4) step();
    RST_N = 1'b0;
    #1;
    tests_run++;
    if (obs !== 13'd0) begin
      tests_failed++;
      $display("FAIL mid_pending_reset: got %b expected %b", obs, 13'd0);
    end
    repeat (2) step();
    RST_N = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      st = (e >= 6) ? 4'b0100 : 4'b0000;
      ro = (e == 6) ? 4'b0100 : 4'b0000;
      tests_run++;
      if (obs !== {st, ro, 4'b0000, (e == 6)}) begin
        tests_failed++;
        $display("FAIL restart_after_reset edge %0d: got %b expected %b", e, obs,
                 {st, ro, 4'b0000, (e == 6)});
      end
    end
  endtask

  task automatic test_high_through_reset();
    logic [3:0] st, ro;
    do_reset();
    SW = 4'b1111;
    repeat (8) step();
    tests_run++;
    if (SW_STABLE !== 4'b1111) begin
      tests_failed++;
      $display("FAIL pre_reset_stable: got %b expected %b", SW_STABLE, 4'b1111);
    end
    RST_N = 1'b0;
    #1;
    tests_run++;
    if (obs !== 13'd0) begin
      tests_failed++;
      $display("FAIL async_clear: got %b expected %b", obs, 13'd0);
    end
    repeat (3) step();
    RST_N = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      st = (e >= 6) ? 4'b1111 : 4'b0000;
      ro = (e == 6) ? 4'b1111 : 4'b0000;
      tests_run++;
      if (obs !== {st, ro, 4'b0000, (e == 6)}) begin
        tests_failed++;
        $display("FAIL high_at_release edge %0d: got %b expected %b", e, obs,
                 {st, ro, 4'b0000, (e == 6)});
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST_N        = 1'b0;
    SW           = 4'b0000;
    test_reset();
    test_single_rise();
    test_glitch();
    test_multi_bit();
    test_reset_mid_pending();
    test_high_through_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
